// File: rtl/fetch_pc.sv
// Program counter and fetch sequencer for the instruction ROM: IDLE/ARM/RUN/DONE with
// priority redirects. Optional return stack is built when PC_RETURN_STACK_EN is defined.
module fetch_pc #(
  parameter int D         = 12,
  parameter int OFS_W     = 8,
  parameter int STK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             halt,
  input  logic             branch_en,
  input  logic [OFS_W-1:0] offset,
  input  logic             jump_en,
  input  logic [D-1:0]     target,
  input  logic             call_en,
  input  logic             ret_en,
  output logic [D-1:0]     prog_ctr,
  output logic             running,
  output logic             done,
  output logic             stk_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [D-1:0]   pc_q, pc_d;
  logic           done_q, done_d;
  logic [D-1:0]   pc_inc;
  logic [D-1:0]   ofs_ext;

  assign pc_inc  = pc_q + 1'b1;
  assign ofs_ext = D'($signed(offset));

`ifdef PC_RETURN_STACK_EN
  localparam int SP_W  = $clog2(STK_DEPTH + 1);
  localparam int IDX_W = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;

  logic [D-1:0]     stk_q [STK_DEPTH];
  logic [SP_W-1:0]  sp_q, sp_d;
  logic             err_q, err_d;
  logic             push_we;
  logic [IDX_W-1:0] push_idx;
  logic [IDX_W-1:0] top_idx;
  logic             stk_full, stk_empty;

  assign stk_full  = (sp_q == SP_W'(STK_DEPTH));
  assign stk_empty = (sp_q == '0);
  assign top_idx   = IDX_W'(sp_q - 1'b1);
  assign stk_err   = err_q;
`else
  logic unused_stack_inputs;
  assign unused_stack_inputs = ^{call_en, ret_en};
  assign stk_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef PC_RETURN_STACK_EN
    err_d    = err_q;
    sp_d     = sp_q;
    push_we  = 1'b0;
    push_idx = '0;
`endif
    unique case (state_q)
      S_IDLE: begin
        pc_d = '0;
        if (start) begin
          state_d = S_ARM;
`ifdef PC_RETURN_STACK_EN
          err_d = 1'b0;
          sp_d  = '0;
`endif
        end
      end
      S_ARM: begin
        pc_d = '0;
        if (!start) state_d = S_RUN;
      end
      S_RUN: begin
        // A restart request overrides every instruction-driven redirect.
        if (start) begin
          state_d = S_ARM;
          pc_d    = '0;
`ifdef PC_RETURN_STACK_EN
          err_d = 1'b0;
          sp_d  = '0;
`endif
        end else if (halt) begin
          state_d = S_DONE;
        end else if (stall) begin
          pc_d = pc_q;
`ifdef PC_RETURN_STACK_EN
        end else if (ret_en) begin
          if (stk_empty) begin
            pc_d  = pc_inc;
            err_d = 1'b1;
          end else begin
            pc_d = stk_q[top_idx];
            sp_d = sp_q - 1'b1;
          end
        end else if (call_en) begin
          pc_d    = target;
          push_we = 1'b1;
          // Overflow replaces the newest entry so the oldest return addresses survive.
          if (stk_full) begin
            push_idx = top_idx;
            err_d    = 1'b1;
          end else begin
            push_idx = IDX_W'(sp_q);
            sp_d     = sp_q + 1'b1;
          end
`endif
        end else if (jump_en) begin
          pc_d = target;
        end else if (branch_en) begin
          pc_d = pc_q + ofs_ext;
        end else begin
          pc_d = pc_inc;
        end
      end
      S_DONE: begin
        if (start) begin
          state_d = S_ARM;
          pc_d    = '0;
`ifdef PC_RETURN_STACK_EN
          err_d = 1'b0;
          sp_d  = '0;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = '0;
      end
    endcase
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      done_q  <= 1'b0;
`ifdef PC_RETURN_STACK_EN
      err_q <= 1'b0;
      sp_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
`ifdef PC_RETURN_STACK_EN
      err_q <= err_d;
      sp_q  <= sp_d;
`endif
    end
  end

`ifdef PC_RETURN_STACK_EN
  always_ff @(posedge clk) begin
    if (push_we) stk_q[push_idx] <= pc_inc;
  end
`endif

  assign prog_ctr = pc_q;
  assign running  = (state_q == S_RUN);
  assign done     = done_q;

endmodule

// File: tb/tb_fetch_pc.sv
// Scoreboarded bench for fetch_pc: directed plan cases plus random sequences against a queue-based model.
module tb_fetch_pc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, stall = 1'b0, halt = 1'b0, branch_en = 1'b0;
  logic [7:0]  offset = '0;
  logic        jump_en = 1'b0;
  logic [11:0] target = '0;
  logic        call_en = 1'b0, ret_en = 1'b0;
  logic [11:0] prog_ctr;
  logic        running, done, stk_err;

  fetch_pc #(.D(12), .OFS_W(8), .STK_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
    .branch_en(branch_en), .offset(offset), .jump_en(jump_en), .target(target),
    .call_en(call_en), .ret_en(ret_en), .prog_ctr(prog_ctr), .running(running),
    .done(done), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pc;
    bit run;
    bit dn;
    bit err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: phase 0 idle, 1 armed, 2 running, 3 finished.
  int   m_phase = 0;
  int   m_pc    = 0;
  bit   m_err   = 0;
  int   m_stk[$];

  task automatic check(input string nm, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
  endtask

  task automatic model_rearm();
    m_phase = 1;
    m_pc    = 0;
    m_err   = 0;
    m_stk.delete();
  endtask

  task automatic model_step(input bit s, st, h, br, input logic [7:0] of, input bit j,
                            input int tg, input bit c, r);
    exp_t e;
    case (m_phase)
      0: if (s) model_rearm();
      1: if (!s) m_phase = 2;
      2: begin
        if (s) model_rearm();
        else if (h) m_phase = 3;
        else if (st) m_pc = m_pc;
`ifdef PC_RETURN_STACK_EN
        else if (r) begin
          if (m_stk.size() == 0) begin
            m_pc  = (m_pc + 1) % 4096;
            m_err = 1;
          end else m_pc = m_stk.pop_back();
        end else if (c) begin
          if (m_stk.size() == 4) begin
            m_stk[3] = (m_pc + 1) % 4096;
            m_err    = 1;
          end else m_stk.push_back((m_pc + 1) % 4096);
          m_pc = tg;
        end
`endif
        else if (j) m_pc = tg;
        else if (br) m_pc = (m_pc + 4096 + int'($signed(of))) % 4096;
        else m_pc = (m_pc + 1) % 4096;
      end
      default: if (s) model_rearm();
    endcase
    e.pc  = m_pc;
    e.run = (m_phase == 2);
    e.dn  = (m_phase == 3);
    e.err = m_err;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit s, st, h, br, input logic [7:0] of, input bit j,
                     input int tg, input bit c, r);
    @(negedge clk);
    start = s; stall = st; halt = h; branch_en = br; offset = of;
    jump_en = j; target = 12'(tg); call_en = c; ret_en = r;
    model_step(s, st, h, br, of, j, tg, c, r);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 8'd0, 0, 0, 0, 0);
  endtask

  task automatic jmp(input int tg);
    cyc(0, 0, 0, 0, 8'd0, 1, tg, 0, 0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: one expected record per clock edge after stimulus was issued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_pc", int'(prog_ctr), e.pc);
        check("sb_running", int'(running), int'(e.run));
        check("sb_done", int'(done), int'(e.dn));
        check("sb_stk_err", int'(stk_err), int'(e.err));
      end
    end
  end

  initial begin
    #1;
    check("rst_pc", int'(prog_ctr), 0);
    check("rst_running", int'(running), 0);
    check("rst_done", int'(done), 0);
    check("rst_stk_err", int'(stk_err), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Launch: ARM holds 0, then 0,1,2,3 in RUN.
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0, 8'd0, 0, 0, 0, 0);
      settle();
      check("arm_pc", int'(prog_ctr), 0);
    end
    cyc(0, 0, 0, 0, 8'd0, 0, 0, 0, 0);
    settle();
    check("launch_pc", int'(prog_ctr), 0);
    check("launch_running", int'(running), 1);
    for (int i = 1; i <= 3; i++) begin
      idle();
      settle();
      check("seq_pc", int'(prog_ctr), i);
    end

    // Branches and wrap.
    jmp(5);
    cyc(0, 0, 0, 1, 8'hFD, 0, 0, 0, 0);
    settle();
    check("branch_back", int'(prog_ctr), 2);
    jmp(4094);
    cyc(0, 0, 0, 1, 8'd5, 0, 0, 0, 0);
    settle();
    check("branch_wrap", int'(prog_ctr), 3);
    jmp(4095);
    idle();
    settle();
    check("inc_wrap", int'(prog_ctr), 0);

    // Priority.
    jmp(10);
    cyc(0, 1, 1, 0, 8'd0, 1, 100, 0, 0);
    settle();
    check("halt_pc", int'(prog_ctr), 10);
    check("halt_done", int'(done), 1);
    check("halt_running", int'(running), 0);
    cyc(1, 0, 0, 0, 8'd0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 8'd0, 0, 0, 0, 0);
    jmp(20);
    cyc(0, 1, 0, 0, 8'd0, 1, 100, 0, 0);
    settle();
    check("stall_over_jump", int'(prog_ctr), 20);
    cyc(0, 0, 0, 1, 8'd3, 1, 100, 0, 0);
    settle();
    check("jump_over_branch", int'(prog_ctr), 100);

    // Restart from DONE.
    jmp(37);
    cyc(0, 0, 1, 0, 8'd0, 0, 0, 0, 0);
    settle();
    check("done_pc", int'(prog_ctr), 37);
    check("done_flag", int'(done), 1);
    cyc(1, 0, 0, 0, 8'd0, 0, 0, 0, 0);
    settle();
    check("restart_done", int'(done), 0);
    check("restart_pc", int'(prog_ctr), 0);
    cyc(0, 0, 0, 0, 8'd0, 0, 0, 0, 0);
    idle();
    settle();
    check("resume_pc", int'(prog_ctr), 1);

`ifdef PC_RETURN_STACK_EN
    for (int k = 1; k <= 5; k++) begin
      jmp(k);
      cyc(0, 0, 0, 0, 8'd0, 0, k * 10, 1, 0);
    end
    settle();
    check("ovf_err", int'(stk_err), 1);
    begin
      int rets[4] = '{6, 4, 3, 2};
      for (int i = 0; i < 4; i++) begin
        cyc(0, 0, 0, 0, 8'd0, 0, 0, 0, 1);
        settle();
        check("ret_pc", int'(prog_ctr), rets[i]);
      end
    end
    cyc(0, 0, 0, 0, 8'd0, 0, 0, 0, 1);
    settle();
    check("underflow_pc", int'(prog_ctr), 3);
`else
    jmp(7);
    cyc(0, 0, 0, 0, 8'd0, 0, 200, 1, 0);
    settle();
    check("call_ignored", int'(prog_ctr), 8);
`endif

    // Asynchronous reset in the middle of RUN.
    jmp(50);
    settle();
    check("pre_reset_pc", int'(prog_ctr), 50);
    #1 reset = 1'b1;
    #1;
    check("async_rst_pc", int'(prog_ctr), 0);
    check("async_rst_running", int'(running), 0);
    m_phase = 0;
    m_pc    = 0;
    m_err   = 0;
    m_stk.delete();
    @(negedge clk);
    reset = 1'b0;

    // Random sequences.
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 29) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0,
          $urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 9) == 0,
          int'($urandom_range(0, 4095)), $urandom_range(0, 6) == 0, $urandom_range(0, 6) == 0);
    end
    idle();
    repeat (2) @(posedge clk);
    #3;
    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_pc.md
# fetch_pc

Program-counter and fetch sequencer that sits directly upstream of the 9-bit instruction ROM. It owns the `prog_ctr` address that indexes the ROM, sequences a program from a start pulse to a halt, and applies branch, jump and optional call/return redirects decoded from the current instruction. Its output drives the ROM address combinationally, so each cycle's decoded instruction steers the next address.

## Interface
Parameters:
- D, 12, program-counter width; must match the instruction ROM address width.
- OFS_W, 8, width of the signed relative-branch offset.
- STK_DEPTH, 4, return-stack entries; used only with PC_RETURN_STACK_EN.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; forces the reset values below immediately.
- start  in  1  level; high arms the program at address 0, the falling edge launches execution.
- stall  in  1  hold `prog_ctr` this cycle (RUN only).
- halt  in  1  current instruction is the halt/done op.
- branch_en  in  1  take a relative branch.
- offset  in  OFS_W  signed two's-complement branch offset.
- jump_en  in  1  take an absolute jump.
- target  in  D  absolute jump/call target.
- call_en  in  1  call: push the return address, go to `target`.
- ret_en  in  1  return: pop the stack into the PC.
- prog_ctr  out  D  registered ROM address.
- running  out  1  high in RUN.
- done  out  1  registered; high in DONE.
- stk_err  out  1  sticky stack overflow/underflow flag.

## Operation
- States: IDLE, ARM, RUN, DONE.
- IDLE: `prog_ctr`=0, `done`=0. `start`=1 -> ARM.
- ARM: `prog_ctr` held at 0. `start`=0 -> RUN, and execution begins at address 0.
- RUN: next PC is chosen by fixed priority, first match wins:
  - `halt`: PC holds and the state moves to DONE.
  - `stall`: PC holds.
  - `ret_en`: pop.
  - `call_en`: push.
  - `jump_en`: PC = `target`.
  - `branch_en`: branch.
  - Otherwise PC+1.
- `start`=1 in RUN -> ARM (restart), with PC=0 on the next edge.
- DONE: `done`=1 and PC holds at the halt address. `start`=1 -> ARM, clearing `done`.
- Arithmetic, modulo 2^D with no flag:
  - Branch: PC + sign-extended `offset`.
  - PC+1 at 2^D-1 wraps to 0.
  - A negative branch below 0 wraps.
- Redirect inputs are ignored outside RUN.
- Reset values: state IDLE, `prog_ctr`=0, `running`=0, `done`=0, `stk_err`=0, stack pointer 0. Reset asserted mid-run aborts immediately; there is no completion of the in-flight cycle.

## Timing
- The ROM is combinational, so the instruction at `prog_ctr` is valid in the same cycle.
- All redirect inputs are sampled on the edge ending that cycle, giving 1-cycle redirect latency and no delay slots.
- Launch: `start` falling with the edge sampling `start`=0 in ARM; address 0 executes during the first RUN cycle.
- `done` rises on the edge after the halt cycle.
- `running` falls on that same edge.

## Configuration
- PC_RETURN_STACK_EN defined: the STK_DEPTH-entry LIFO is enabled.
  - Call pushes PC+1 (mod 2^D) and loads `target`.
  - Return loads the popped value.
  - Push when full overwrites the top entry; the pointer does not move and `stk_err` is set.
  - Pop when empty does PC+1 and sets `stk_err`.
  - `stk_err` clears only on reset or the ARM entry.
- Not defined: no stack storage is built.
  - `call_en` and `ret_en` are ignored and fall through to the lower-priority cases.
  - `stk_err` is tied to 0.

## Test plan
- Reset/launch: reset, then `start` 1 for 3 cycles and 0 -> `prog_ctr` reads 0 throughout ARM, then 0,1,2,3 on successive RUN cycles.
- Branch/wrap:
  - At PC 5, `branch_en` with `offset`=-3 -> next PC 2.
  - At PC 4094, `offset`=+5 -> next PC 3.
  - Free-run from 4095 -> 0.
- Priority:
  - At PC 10 with `halt`, `stall`, `jump_en` (`target`=100) all high -> PC stays 10 and `done`=1 next cycle.
  - At PC 20 with `stall`+`jump_en` -> PC stays 20.
  - At PC 20 with `jump_en`+`branch_en` -> PC = `target`.
- Restart: in DONE at PC 37, pulse `start` -> `done`=0, PC 0, and RUN resumes from 0 after `start` falls.
- Asynchronous reset mid-RUN at PC 50 -> `prog_ctr`=0 and `running`=0 immediately, before the next edge.
- With PC_RETURN_STACK_EN:
  - 5 nested calls from PC 1,2,3,4,5 (`target`=k×10) with depth 4 -> `stk_err`=1 after the 5th call.
  - 4 returns yield 6,4,3,2.
  - A 5th return gives PC+1.
  - Without the macro, `call_en` at PC 7 gives PC 8.
